// File: rtl/enemy_life_ctrl.sv
// Per-enemy life/combat controller: HP, post-hit invulnerability, respawn
// timing and rate-limited player-damage pulses, one update per game frame.
module enemy_life_ctrl #(
    parameter int unsigned MAX_HP         = 8,
    parameter int unsigned INVULN_FRAMES  = 6,
    parameter int unsigned RESPAWN_FRAMES = 120,
    parameter int unsigned ATTACK_PERIOD  = 30
) (
    input  logic       game_frame_clk_rising_edge,
    input  logic       Reset,
    input  logic       Bullet_Hit,
    input  logic [3:0] Hit_Damage,
    input  logic       Enemy_Attack_Ready,
    output logic       is_alive,
    output logic       Enemy_Is_Attacked,
    output logic [3:0] Enemy_HP,
    output logic       Kill_Pulse,
    output logic       Respawn_Pulse,
    output logic       Player_Damage_Pulse
);

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam logic [3:0] HP_INIT   = 4'(MAX_HP);
    localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] DEAD_LOAD = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] ATK_LOAD  = 8'(ATTACK_PERIOD - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] hp_q, hp_d;
    logic [7:0] inv_q, inv_d;
    logic [7:0] dead_q, dead_d;
    logic [7:0] atk_q, atk_d;
    logic       alive_q;
    logic       att_q, att_d;
    logic       kill_q, kill_d;
    logic       resp_q, resp_d;
    logic       dmg_q, dmg_d;

    logic       hit_ok;
    logic       lethal;
    logic [4:0] diff;
    logic [3:0] hp_sub;
    logic [7:0] atk_tick;

    // 5-bit subtract so an overkill borrow saturates HP at zero
    assign diff     = {1'b0, hp_q} - {1'b0, Hit_Damage};
    assign hp_sub   = diff[4] ? 4'd0 : diff[3:0];
    assign hit_ok   = Bullet_Hit && (Hit_Damage != 4'd0)
                      && (state_q == ST_ALIVE);
    assign lethal   = hit_ok && (hp_sub == 4'd0);
    assign atk_tick = (atk_q != 8'd0) ? atk_q - 8'd1 : 8'd0;

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        inv_d   = inv_q;
        dead_d  = dead_q;
        atk_d   = atk_q;
        att_d   = 1'b0;
        kill_d  = 1'b0;
        resp_d  = 1'b0;
        dmg_d   = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                atk_d = atk_tick;
                if (hit_ok) begin
                    if (lethal) begin
                        hp_d    = 4'd0;
                        kill_d  = 1'b1;
                        dead_d  = DEAD_LOAD;
                        state_d = ST_DEAD;
                    end else begin
                        hp_d    = hp_sub;
                        att_d   = 1'b1;
                        inv_d   = INV_LOAD;
                        state_d = ST_INVULN;
                    end
                end
                // a killing blow suppresses the same-frame attack
                if (Enemy_Attack_Ready && (atk_q == 8'd0) && !lethal) begin
                    dmg_d = 1'b1;
                    atk_d = ATK_LOAD;
                end
            end
            ST_INVULN: begin
                atk_d = atk_tick;
                if (inv_q == 8'd0) begin
                    state_d = ST_ALIVE;
                end else begin
                    inv_d = inv_q - 8'd1;
                end
            end
            ST_DEAD: begin
                atk_d = 8'd0;
                if (dead_q == 8'd0) begin
                    state_d = ST_ALIVE;
                    hp_d    = HP_INIT;
                    resp_d  = 1'b1;
                end else begin
                    dead_d = dead_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    always_ff @(posedge game_frame_clk_rising_edge) begin
        if (Reset) begin
            state_q <= ST_ALIVE;
            hp_q    <= HP_INIT;
            inv_q   <= 8'd0;
            dead_q  <= 8'd0;
            atk_q   <= 8'd0;
            alive_q <= 1'b1;
            att_q   <= 1'b0;
            kill_q  <= 1'b0;
            resp_q  <= 1'b0;
            dmg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            inv_q   <= inv_d;
            dead_q  <= dead_d;
            atk_q   <= atk_d;
            alive_q <= (state_d != ST_DEAD);
            att_q   <= att_d;
            kill_q  <= kill_d;
            resp_q  <= resp_d;
            dmg_q   <= dmg_d;
        end
    end

    assign is_alive            = alive_q;
    assign Enemy_Is_Attacked   = att_q;
    assign Enemy_HP            = hp_q;
    assign Kill_Pulse          = kill_q;
    assign Respawn_Pulse       = resp_q;
    assign Player_Damage_Pulse = dmg_q;

endmodule
